// File: rtl/cpld_uart_responder_if.sv
// Strobe/data bus between the CPU's UART controller (master) and the CPLD responder (slave).
interface cpld_uart_responder_if;
   logic       uart_rdn;
   logic       uart_wrn;
   logic [7:0] bus_data_in;
   logic [7:0] bus_data_out;
   logic       bus_data_oe;
   logic       uart_dataready;
   logic       uart_tbre;
   logic       uart_tsre;

   modport master (
      output uart_rdn, uart_wrn, bus_data_in,
      input  bus_data_out, bus_data_oe, uart_dataready, uart_tbre, uart_tsre
   );

   modport slave (
      input  uart_rdn, uart_wrn, bus_data_in,
      output bus_data_out, bus_data_oe, uart_dataready, uart_tbre, uart_tsre
   );
endinterface

// File: rtl/cpld_uart_responder.sv
// CPLD UART responder: strobe decode, 8N1 THR/TSR transmitter and single-RBR receiver.
// UART_LOOPBACK_EN routes the internal txd into the receiver instead of the rxd pin.
module cpld_uart_responder #(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 115200
) (
   input  logic                        clk,
   input  logic                        rst,
   cpld_uart_responder_if.slave        bus,
   output logic                        txd,
   input  logic                        rxd
);
   localparam int DIV = CLK_FREQ / BAUD;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic r_wrn_d, r_rdn_d;
   logic w_wr_edge, w_rd_rise;

   state_t        r_tx_state, w_tx_state_n;
   logic [CW-1:0] r_tx_cnt, w_tx_cnt_n;
   logic [2:0]    r_tx_bit, w_tx_bit_n;
   logic [7:0]    r_tx_shift, w_tx_shift_n;
   logic [7:0]    r_thr, w_thr_n;
   logic          r_tbre, w_tbre_n;
   logic          r_tsre, w_tsre_n;
   logic          w_txd_line;

   logic          r_rx_s1, r_rx_s2, r_rx_prev;
   logic          w_rx_src;
   state_t        r_rx_state, w_rx_state_n;
   logic [CW-1:0] r_rx_cnt, w_rx_cnt_n;
   logic [2:0]    r_rx_bit, w_rx_bit_n;
   logic [7:0]    r_rx_shift, w_rx_shift_n;
   logic [7:0]    r_rbr, w_rbr_n;
   logic          r_dataready, w_dataready_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrn_d <= 1'b1;
         r_rdn_d <= 1'b1;
      end else begin
         r_wrn_d <= bus.uart_wrn;
         r_rdn_d <= bus.uart_rdn;
      end
   end

   assign w_wr_edge = r_wrn_d & ~bus.uart_wrn;
   assign w_rd_rise = ~r_rdn_d & bus.uart_rdn;

   // Writes and reloads never collide: a write needs tbre=1, a reload needs tbre=0.
   always_comb begin
      w_tx_state_n = r_tx_state;
      w_tx_cnt_n   = r_tx_cnt;
      w_tx_bit_n   = r_tx_bit;
      w_tx_shift_n = r_tx_shift;
      w_thr_n      = r_thr;
      w_tbre_n     = r_tbre;
      w_tsre_n     = r_tsre;
      w_txd_line   = 1'b1;
      if (w_wr_edge && r_tbre) begin
         w_thr_n  = bus.bus_data_in;
         w_tbre_n = 1'b0;
      end
      case (r_tx_state)
         S_IDLE: begin
            if (!r_tbre) begin
               w_tx_shift_n = r_thr;
               w_tbre_n     = 1'b1;
               w_tsre_n     = 1'b0;
               w_tx_cnt_n   = '0;
               w_tx_state_n = S_START;
            end
         end
         S_START: begin
            w_txd_line = 1'b0;
            if (r_tx_cnt == CNT_LAST) begin
               w_tx_cnt_n   = '0;
               w_tx_bit_n   = 3'd0;
               w_tx_state_n = S_DATA;
            end else begin
               w_tx_cnt_n = r_tx_cnt + 1'b1;
            end
         end
         S_DATA: begin
            w_txd_line = r_tx_shift[r_tx_bit];
            if (r_tx_cnt == CNT_LAST) begin
               w_tx_cnt_n = '0;
               w_tx_bit_n = r_tx_bit + 3'd1;
               if (r_tx_bit == 3'd7) w_tx_state_n = S_STOP;
            end else begin
               w_tx_cnt_n = r_tx_cnt + 1'b1;
            end
         end
         S_STOP: begin
            if (r_tx_cnt == CNT_LAST) begin
               w_tx_cnt_n = '0;
               if (!r_tbre) begin
                  w_tx_shift_n = r_thr;
                  w_tbre_n     = 1'b1;
                  w_tx_state_n = S_START;
               end else begin
                  w_tsre_n     = 1'b1;
                  w_tx_state_n = S_IDLE;
               end
            end else begin
               w_tx_cnt_n = r_tx_cnt + 1'b1;
            end
         end
         default: w_tx_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_state <= S_IDLE;
         r_tx_cnt   <= '0;
         r_tx_bit   <= 3'd0;
         r_tx_shift <= 8'd0;
         r_thr      <= 8'd0;
         r_tbre     <= 1'b1;
         r_tsre     <= 1'b1;
      end else begin
         r_tx_state <= w_tx_state_n;
         r_tx_cnt   <= w_tx_cnt_n;
         r_tx_bit   <= w_tx_bit_n;
         r_tx_shift <= w_tx_shift_n;
         r_thr      <= w_thr_n;
         r_tbre     <= w_tbre_n;
         r_tsre     <= w_tsre_n;
      end
   end

   // Reset forces the line idle in the same cycle, not only after the edge.
   assign txd = w_txd_line | rst;

`ifdef UART_LOOPBACK_EN
   assign w_rx_src = txd;
`else
   assign w_rx_src = rxd;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_s1   <= 1'b1;
         r_rx_s2   <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_s1   <= w_rx_src;
         r_rx_s2   <= r_rx_s1;
         r_rx_prev <= r_rx_s2;
      end
   end

   // Clear is applied before the stop-bit set so a coincident set wins.
   always_comb begin
      w_rx_state_n  = r_rx_state;
      w_rx_cnt_n    = r_rx_cnt;
      w_rx_bit_n    = r_rx_bit;
      w_rx_shift_n  = r_rx_shift;
      w_rbr_n       = r_rbr;
      w_dataready_n = r_dataready;
      if (w_rd_rise) w_dataready_n = 1'b0;
      case (r_rx_state)
         S_IDLE: begin
            if (r_rx_prev && !r_rx_s2) begin
               w_rx_cnt_n   = '0;
               w_rx_state_n = S_START;
            end
         end
         S_START: begin
            if (r_rx_cnt == CNT_HALF) begin
               w_rx_cnt_n   = '0;
               w_rx_bit_n   = 3'd0;
               w_rx_state_n = r_rx_s2 ? S_IDLE : S_DATA;
            end else begin
               w_rx_cnt_n = r_rx_cnt + 1'b1;
            end
         end
         S_DATA: begin
            if (r_rx_cnt == CNT_LAST) begin
               w_rx_cnt_n   = '0;
               w_rx_shift_n = {r_rx_s2, r_rx_shift[7:1]};
               w_rx_bit_n   = r_rx_bit + 3'd1;
               if (r_rx_bit == 3'd7) w_rx_state_n = S_STOP;
            end else begin
               w_rx_cnt_n = r_rx_cnt + 1'b1;
            end
         end
         S_STOP: begin
            if (r_rx_cnt == CNT_LAST) begin
               w_rx_cnt_n   = '0;
               w_rx_state_n = S_IDLE;
               if (r_rx_s2) begin
                  w_rbr_n       = r_rx_shift;
                  w_dataready_n = 1'b1;
               end
            end else begin
               w_rx_cnt_n = r_rx_cnt + 1'b1;
            end
         end
         default: w_rx_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_state  <= S_IDLE;
         r_rx_cnt    <= '0;
         r_rx_bit    <= 3'd0;
         r_rx_shift  <= 8'd0;
         r_rbr       <= 8'd0;
         r_dataready <= 1'b0;
      end else begin
         r_rx_state  <= w_rx_state_n;
         r_rx_cnt    <= w_rx_cnt_n;
         r_rx_bit    <= w_rx_bit_n;
         r_rx_shift  <= w_rx_shift_n;
         r_rbr       <= w_rbr_n;
         r_dataready <= w_dataready_n;
      end
   end

   assign bus.bus_data_out   = r_rbr;
   assign bus.bus_data_oe    = ~bus.uart_rdn & ~rst;
   assign bus.uart_dataready = r_dataready & ~rst;
   assign bus.uart_tbre      = r_tbre | rst;
   assign bus.uart_tsre      = r_tsre | rst;
endmodule
